// File: rtl/retire_pkg.sv
// Shared types for the retire pair buffer: the RVFI-derived retire record
// and its field layout.
package retire_pkg;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc_wdata;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
   } retire_rec_t;

   localparam int REC_W = $bits(retire_rec_t);

   localparam int INSN_LSB      = 96;
   localparam int PC_WDATA_LSB  = 64;
   localparam int MEM_ADDR_LSB  = 32;
   localparam int MEM_WDATA_LSB = 0;

   // Occupancy counters need one extra bit so that "full" (== depth) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/retire_pair_buf_if.sv
// Retire-side and pair-side signals of the retire pair buffer.
// timeout_o exists only when RETIRE_PAIR_TIMEOUT_EN is defined.
interface retire_pair_buf_if #(
   parameter int DEPTH = 4,
   parameter int REC_W = retire_pkg::REC_W
);
   localparam int CNT_W = retire_pkg::cnt_w(DEPTH);

   logic             retire_1_i;
   logic [REC_W-1:0] rec_1_i;
   logic             retire_2_i;
   logic [REC_W-1:0] rec_2_i;
   logic             stall_1_o;
   logic             stall_2_o;
   logic             pair_valid_o;
   logic             pair_ready_i;
   logic [REC_W-1:0] pair_rec_1_o;
   logic [REC_W-1:0] pair_rec_2_o;
   logic [CNT_W-1:0] count_1_o;
   logic [CNT_W-1:0] count_2_o;
   logic             overflow_o;
`ifdef RETIRE_PAIR_TIMEOUT_EN
   logic             timeout_o;
`endif

   // Buffer side.
   modport slave (
      input  retire_1_i, rec_1_i, retire_2_i, rec_2_i, pair_ready_i,
      output stall_1_o, stall_2_o, pair_valid_o, pair_rec_1_o, pair_rec_2_o,
             count_1_o, count_2_o, overflow_o
`ifdef RETIRE_PAIR_TIMEOUT_EN
      , output timeout_o
`endif
   );

   // Harness side: cores and comparator.
   modport master (
      output retire_1_i, rec_1_i, retire_2_i, rec_2_i, pair_ready_i,
      input  stall_1_o, stall_2_o, pair_valid_o, pair_rec_1_o, pair_rec_2_o,
             count_1_o, count_2_o, overflow_o
`ifdef RETIRE_PAIR_TIMEOUT_EN
      , input timeout_o
`endif
   );

endinterface

// File: rtl/retire_fifo.sv
// First-word-fall-through FIFO holding one core's retire records.
// drop pulses for one cycle when a push is rejected because the FIFO is full.
module retire_fifo #(
   parameter int DEPTH = 4,
   parameter int REC_W = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [REC_W-1:0]         wdata,
   output logic [REC_W-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == (AW + 1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop && !empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign wr_en = push && (!full || rd_en);
   assign drop  = push && !wr_en;
   assign rdata = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the cleared pointers and count
   // make stale contents unreachable, and this keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/retire_pair_buf.sv
// Buffers both cores' retire records and releases them strictly in pairs,
// stalling the core that runs ahead. RETIRE_PAIR_TIMEOUT_EN adds timeout_o.
module retire_pair_buf
   import retire_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int REC_W   = retire_pkg::REC_W,
   parameter int TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   retire_pair_buf_if.slave  bus
);
   localparam int CNT_W = cnt_w(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("retire_pair_buf: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   logic [REC_W-1:0] rdata_1, rdata_2;
   logic [CNT_W-1:0] count_1, count_2;
   logic             full_1, full_2;
   logic             empty_1, empty_2;
   logic             drop_1, drop_2;
   logic             pair_valid;
   logic             pair_pop;
   logic             overflow;

   assign pair_valid = !empty_1 && !empty_2;
   assign pair_pop   = pair_valid && bus.pair_ready_i;

   retire_fifo #(.DEPTH(DEPTH), .REC_W(REC_W)) u_fifo_1 (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (bus.retire_1_i),
      .pop   (pair_pop),
      .wdata (bus.rec_1_i),
      .rdata (rdata_1),
      .count (count_1),
      .full  (full_1),
      .empty (empty_1),
      .drop  (drop_1)
   );

   retire_fifo #(.DEPTH(DEPTH), .REC_W(REC_W)) u_fifo_2 (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (bus.retire_2_i),
      .pop   (pair_pop),
      .wdata (bus.rec_2_i),
      .rdata (rdata_2),
      .count (count_2),
      .full  (full_2),
      .empty (empty_2),
      .drop  (drop_2)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)                 overflow <= 1'b0;
      else if (drop_1 || drop_2) overflow <= 1'b1;
   end

   // Stall one entry early: the clock gate takes a cycle to freeze the core.
   assign bus.stall_1_o    = full_1 || (count_1 == CNT_W'(DEPTH - 1));
   assign bus.stall_2_o    = full_2 || (count_2 == CNT_W'(DEPTH - 1));
   assign bus.pair_valid_o = pair_valid;
   assign bus.pair_rec_1_o = pair_valid ? rdata_1 : '0;
   assign bus.pair_rec_2_o = pair_valid ? rdata_2 : '0;
   assign bus.count_1_o    = count_1;
   assign bus.count_2_o    = count_2;
   assign bus.overflow_o   = overflow;

`ifdef RETIRE_PAIR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt;
   logic            one_side;
   logic            timeout;

   assign one_side = empty_1 ^ empty_2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (!one_side)                       to_cnt <= '0;
         else if (to_cnt != TO_W'(TIMEOUT))   to_cnt <= to_cnt + 1'b1;
         if (one_side && to_cnt == TO_W'(TIMEOUT - 1)) timeout <= 1'b1;
      end
   end

   assign bus.timeout_o = timeout;
`endif

endmodule

// File: tb/tb_retire_pair_buf.sv
// Directed, table-driven bench for retire_pair_buf (DEPTH=4, TIMEOUT=8);
// the timeout sequence runs only when RETIRE_PAIR_TIMEOUT_EN is defined.
module tb_retire_pair_buf;
   import retire_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   typedef struct {
      logic        rst;
      logic        r1;
      retire_rec_t d1;
      logic        r2;
      retire_rec_t d2;
      logic        rdy;
      logic        e_valid;
      retire_rec_t e_rec1;
      retire_rec_t e_rec2;
      int          e_c1;
      int          e_c2;
      logic        e_s1;
      logic        e_s2;
      logic        e_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   retire_pair_buf_if #(.DEPTH(DEPTH), .REC_W(REC_W)) bus ();

   retire_pair_buf #(.DEPTH(DEPTH), .REC_W(REC_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // Distinct, recognisable record per id; id 0 stands for the all-zero record.
   function automatic retire_rec_t mk_rec(input int n);
      retire_rec_t r;
      if (n == 0) return '0;
      r.insn      = 32'hC0DE_0000 | 32'(n);
      r.pc_wdata  = 32'h8000_0000 + 32'(4 * n);
      r.mem_addr  = 32'h1000_0000 + 32'(n);
      r.mem_wdata = ~32'(n);
      return r;
   endfunction

   function automatic vec_t mkv(input logic rst_v, input logic r1, input int n1,
                                input logic r2, input int n2, input logic rdy,
                                input logic ev, input int e1, input int e2,
                                input int c1, input int c2,
                                input logic s1, input logic s2, input logic ov);
      vec_t v;
      v.rst = rst_v; v.r1 = r1; v.d1 = mk_rec(n1); v.r2 = r2; v.d2 = mk_rec(n2);
      v.rdy = rdy; v.e_valid = ev; v.e_rec1 = mk_rec(e1); v.e_rec2 = mk_rec(e2);
      v.e_c1 = c1; v.e_c2 = c2; v.e_s1 = s1; v.e_s2 = s2; v.e_ovf = ov;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      rst              = v.rst;
      bus.retire_1_i   = v.r1;
      bus.rec_1_i      = v.d1;
      bus.retire_2_i   = v.r2;
      bus.rec_2_i      = v.d2;
      bus.pair_ready_i = v.rdy;
   endtask

   task automatic compare(input string tag, input vec_t v);
      check({tag, " pair_valid"}, 128'(bus.pair_valid_o), 128'(v.e_valid));
      check({tag, " pair_rec_1"}, bus.pair_rec_1_o, v.e_rec1);
      check({tag, " pair_rec_2"}, bus.pair_rec_2_o, v.e_rec2);
      check({tag, " count_1"},    128'(bus.count_1_o), 128'(v.e_c1));
      check({tag, " count_2"},    128'(bus.count_2_o), 128'(v.e_c2));
      check({tag, " stall_1"},    128'(bus.stall_1_o), 128'(v.e_s1));
      check({tag, " stall_2"},    128'(bus.stall_2_o), 128'(v.e_s2));
      check({tag, " overflow"},   128'(bus.overflow_o), 128'(v.e_ovf));
   endtask

   vec_t vecs[$];

   initial begin
      // Core 1 ids: A=1, B=11..15, D=21..25, F=31..33, H=41. Core 2 ids are +100.
      // Fields: rst r1 n1 r2 n2 rdy | valid rec1 rec2 c1 c2 s1 s2 ovf
      // Lockstep push then pop.
      vecs.push_back(mkv(0, 1,  1, 1, 101, 1,  1,  1, 101, 1, 1, 0, 0, 0));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  0,  0,   0, 0, 0, 0, 0, 0));
      // Core 1 runs ahead; stall at DEPTH-1.
      vecs.push_back(mkv(0, 1, 11, 0,   0, 1,  0,  0,   0, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 12, 0,   0, 1,  0,  0,   0, 2, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 13, 0,   0, 1,  0,  0,   0, 3, 0, 1, 0, 0));
      // Fill, then a dropped push sets sticky overflow.
      vecs.push_back(mkv(0, 1, 14, 0,   0, 0,  0,  0,   0, 4, 0, 1, 0, 0));
      vecs.push_back(mkv(0, 1, 15, 0,   0, 0,  0,  0,   0, 4, 0, 1, 0, 1));
      vecs.push_back(mkv(0, 0,  0, 1, 111, 0,  1, 11, 111, 4, 1, 1, 0, 1));
      vecs.push_back(mkv(0, 0,  0, 1, 112, 0,  1, 11, 111, 4, 2, 1, 0, 1));
      vecs.push_back(mkv(0, 0,  0, 1, 113, 0,  1, 11, 111, 4, 3, 1, 1, 1));
      vecs.push_back(mkv(0, 0,  0, 1, 114, 0,  1, 11, 111, 4, 4, 1, 1, 1));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  1, 12, 112, 3, 3, 1, 1, 1));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  1, 13, 113, 2, 2, 0, 0, 1));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  1, 14, 114, 1, 1, 0, 0, 1));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  0,  0,   0, 0, 0, 0, 0, 1));
      // Reset beats simultaneous pushes and clears overflow.
      vecs.push_back(mkv(1, 1, 15, 1, 115, 1,  0,  0,   0, 0, 0, 0, 0, 0));
      // Both full, push+pop together, pointers wrap.
      vecs.push_back(mkv(0, 1, 21, 1, 121, 0,  1, 21, 121, 1, 1, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 22, 1, 122, 0,  1, 21, 121, 2, 2, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 23, 1, 123, 0,  1, 21, 121, 3, 3, 1, 1, 0));
      vecs.push_back(mkv(0, 1, 24, 1, 124, 0,  1, 21, 121, 4, 4, 1, 1, 0));
      vecs.push_back(mkv(0, 1, 25, 1, 125, 1,  1, 22, 122, 4, 4, 1, 1, 0));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  1, 23, 123, 3, 3, 1, 1, 0));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  1, 24, 124, 2, 2, 0, 0, 0));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  1, 25, 125, 1, 1, 0, 0, 0));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  0,  0,   0, 0, 0, 0, 0, 0));
      // Reset at counts 2/1 with a push on core 1; pushed record discarded.
      vecs.push_back(mkv(0, 1, 31, 1, 131, 0,  1, 31, 131, 1, 1, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 32, 0,   0, 0,  1, 31, 131, 2, 1, 0, 0, 0));
      vecs.push_back(mkv(1, 1, 33, 0,   0, 0,  0,  0,   0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 0,  0,  0,   0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 41, 1, 141, 0,  1, 41, 141, 1, 1, 0, 0, 0));
      vecs.push_back(mkv(0, 0,  0, 0,   0, 1,  0,  0,   0, 0, 0, 0, 0, 0));

      drive(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      tick();
      compare("reset", mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         tick();
         compare($sformatf("vec%0d", i), vecs[i]);
      end

`ifdef RETIRE_PAIR_TIMEOUT_EN
      // One-sided occupancy: timeout rises TIMEOUT cycles after the record is visible.
      drive(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      check("timeout after reset", 128'(bus.timeout_o), 128'(0));
      drive(mkv(0, 1, 51, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("timeout at push", 128'(bus.timeout_o), 128'(0));
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         check($sformatf("timeout cycle %0d", k), 128'(bus.timeout_o), 128'(k == TIMEOUT));
      end
      drive(mkv(0, 0, 0, 1, 151, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      drive(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      check("timeout sticky after pair", 128'(bus.timeout_o), 128'(1));
      tick();
      check("timeout sticky after pop", 128'(bus.timeout_o), 128'(1));
      check("timeout pop count_1", 128'(bus.count_1_o), 128'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
